// File: rtl/register_file_scoreboard_pkg.sv
// Shared defaults and storage types for the register file with pending-bit scoreboard.
package register_file_scoreboard_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REGS   = 4;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_scoreboard_if.sv
// Decode/writeback bus of the register file: read ports, write port, reserve and flush.
interface register_file_scoreboard_if
    import register_file_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  RegWrite_Enable;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [ADDR_WIDTH-1:0] RegisterData1;
    logic [ADDR_WIDTH-1:0] RegisterData2;
    logic [DATA_WIDTH-1:0] Data1;
    logic [DATA_WIDTH-1:0] Data2;
    logic                  Data1_Valid;
    logic                  Data2_Valid;
    logic                  Reserve_Enable;
    logic [ADDR_WIDTH-1:0] Reserve_Register;
    logic                  Reserve_Ready;
    logic                  Flush;

    modport master (
        output RegWrite_Enable, WriteRegister, WriteData, RegisterData1, RegisterData2,
        output Reserve_Enable, Reserve_Register, Flush,
        input  Data1, Data2, Data1_Valid, Data2_Valid, Reserve_Ready
    );

    modport slave (
        input  RegWrite_Enable, WriteRegister, WriteData, RegisterData1, RegisterData2,
        input  Reserve_Enable, Reserve_Register, Flush,
        output Data1, Data2, Data1_Valid, Data2_Valid, Reserve_Ready
    );
endinterface

// File: rtl/register_file_scoreboard_reg_scoreboard.sv
// Pending-bit vector: one bit per register, set by an issued producer, cleared by its writeback.
module reg_scoreboard #(
    parameter int NUM_REGS   = 4,
    parameter bit ZERO_REG   = 1'b0,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    input  logic                  flush,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  rsv_ready
);
    logic [NUM_REGS-1:0] pending_nxt;
    logic                rsv_zero;

    assign rsv_zero  = ZERO_REG && (rsv_addr == '0);
    // A writeback landing this edge frees the slot, so a new producer may claim it at once.
    assign rsv_ready = rsv_zero || !pending[rsv_addr] || (clr_en && (clr_addr == rsv_addr));

    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rsv_en && rsv_ready && !rsv_zero && (rsv_addr == ADDR_WIDTH'(i)))
                    pending_nxt[i] = 1'b1;
                else if (clr_en && (clr_addr == ADDR_WIDTH'(i)))
                    pending_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending <= '0;
        else       pending <= pending_nxt;
    end
endmodule

// File: rtl/register_file_scoreboard.sv
// Register file with two combinational read ports, one write port, write bypass and pending scoreboard.
module register_file_scoreboard
    import register_file_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter bit ZERO_REG   = 1'b0,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    register_file_scoreboard_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;
    logic                  wr_en;
    logic                  byp1;
    logic                  byp2;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Writes to a hardwired zero register are dropped before they reach storage or bypass.
    assign wr_en = bus.RegWrite_Enable && !is_zero(bus.WriteRegister);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[bus.WriteRegister] <= bus.WriteData;
        end
    end

    assign byp1 = BYPASS && wr_en && (bus.RegisterData1 == bus.WriteRegister);
    assign byp2 = BYPASS && wr_en && (bus.RegisterData2 == bus.WriteRegister);

    assign bus.Data1 = is_zero(bus.RegisterData1) ? '0 :
                       (byp1 ? bus.WriteData : regs[bus.RegisterData1]);
    assign bus.Data2 = is_zero(bus.RegisterData2) ? '0 :
                       (byp2 ? bus.WriteData : regs[bus.RegisterData2]);

    assign bus.Data1_Valid = !pending[bus.RegisterData1] || byp1;
    assign bus.Data2_Valid = !pending[bus.RegisterData2] || byp2;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .clr_en    (bus.RegWrite_Enable),
        .clr_addr  (bus.WriteRegister),
        .rsv_en    (bus.Reserve_Enable),
        .rsv_addr  (bus.Reserve_Register),
        .flush     (bus.Flush),
        .pending   (pending),
        .rsv_ready (bus.Reserve_Ready)
    );
endmodule
